// File: rtl/dram64x4_wr_arbiter_if.sv
// dram64x4_wr_arbiter_if: requester handshakes, read ports and status of the 64x4 write arbiter.
interface dram64x4_wr_arbiter_if;
    logic       req0_valid;
    logic [5:0] req0_addr;
    logic [3:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [5:0] req1_addr;
    logic [3:0] req1_data;
    logic       req1_ready;
    logic [5:0] rd_addr_a, rd_addr_b, rd_addr_c;
    logic [3:0] rd_data_a, rd_data_b, rd_data_c;
    logic       busy;
    logic       last_grant;
    modport master (
        output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output rd_addr_a, rd_addr_b, rd_addr_c,
        input  req0_ready, req1_ready, rd_data_a, rd_data_b, rd_data_c, busy, last_grant
    );
    modport slave (
        input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  rd_addr_a, rd_addr_b, rd_addr_c,
        output req0_ready, req1_ready, rd_data_a, rd_data_b, rd_data_c, busy, last_grant
    );
endinterface

// File: rtl/dram64x4_wr_arbiter.sv
// dram64x4_wr_arbiter: round-robin write-port arbiter for a RAM64M-style 64x4 memory.
// Post-reset clear sweep is present only when DRAM64X4_ARB_CLEAR_EN is defined.
module dram64x4_wr_arbiter #(
    parameter logic [3:0]  CLEAR_VALUE = 4'h0,
    parameter logic [63:0] INIT_A      = 64'h0,
    parameter logic [63:0] INIT_B      = 64'h0,
    parameter logic [63:0] INIT_C      = 64'h0,
    parameter logic [63:0] INIT_D      = 64'h0
) (
    input logic                   clk,
    input logic                   rst,
    dram64x4_wr_arbiter_if.slave  bus
);
    logic [63:0] slice_q [4] = '{INIT_A, INIT_B, INIT_C, INIT_D};
    logic        last_grant_q;
    logic        gnt0, gnt1, we, busy, clr_we;
    logic [5:0]  waddr, clr_cnt;
    logic [3:0]  wdata;
`ifdef DRAM64X4_ARB_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_e;
    state_e     state_q, state_d;
    logic [5:0] clr_cnt_q, clr_cnt_d;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 6'd1;
            state_d   = &clr_cnt_q ? RUN : CLEAR;
        end
    end
    assign busy    = rst | (state_q == CLEAR);
    assign clr_we  = ~rst & (state_q == CLEAR);
    assign clr_cnt = clr_cnt_q;
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_cnt = '0;
`endif
    // On contention the requester that did not win last time gets the port.
    always_comb begin
        gnt0  = ~busy & ~rst & bus.req0_valid & (~bus.req1_valid | last_grant_q);
        gnt1  = ~busy & ~rst & bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        we    = gnt0 | gnt1 | clr_we;
        waddr = gnt1 ? bus.req1_addr : gnt0 ? bus.req0_addr : clr_cnt;
        wdata = gnt1 ? bus.req1_data : gnt0 ? bus.req0_data : CLEAR_VALUE;
    end
    always_ff @(posedge clk) begin
        if (rst)
            last_grant_q <= 1'b1;
        else if (gnt0 | gnt1)
            last_grant_q <= gnt1;
    end
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++) slice_q[i][waddr] <= wdata[i];
    end
    always_comb begin
        bus.rd_data_a = '0;
        bus.rd_data_b = '0;
        bus.rd_data_c = '0;
        for (int i = 0; i < 4; i++) begin
            bus.rd_data_a[i] = slice_q[i][bus.rd_addr_a];
            bus.rd_data_b[i] = slice_q[i][bus.rd_addr_b];
            bus.rd_data_c[i] = slice_q[i][bus.rd_addr_c];
        end
    end
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.busy       = busy;
    assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_dram64x4_wr_arbiter.sv
// tb_dram64x4_wr_arbiter: directed self-checking bench for the 64x4 write arbiter.
// Covers both builds; clear-sweep checks compile in when DRAM64X4_ARB_CLEAR_EN is defined.
module tb_dram64x4_wr_arbiter;
`ifdef DRAM64X4_ARB_CLEAR_EN
    localparam logic [3:0] P5 = 4'hA, P10 = 4'hA, BUSY_RST = 4'h1;
`else
    localparam logic [3:0] P5 = 4'h0, P10 = 4'h0, BUSY_RST = 4'h0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_err = 0;
    int   i0, i1;
    dram64x4_wr_arbiter_if bus ();
    dram64x4_wr_arbiter #(
        .CLEAR_VALUE (4'hA),
        .INIT_A      (64'h80),
        .INIT_B      (64'h80),
        .INIT_C      (64'h80),
        .INIT_D      (64'h80)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic sweep_wait(input int n);
        for (int k = 0; k < n; k++) begin
            #1;
            check("sweep_state", {5'd0, bus.busy, bus.req0_ready, bus.req1_ready}, 8'h04);
            tick();
        end
    endtask
    task automatic reset_seq;
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd20; bus.req0_data = 4'h7;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd20; bus.req1_data = 4'h8;
        tick();
        tick();
        #1;
        check("rst_ready", {6'd0, bus.req0_ready, bus.req1_ready}, 8'h00);
        check("rst_last_grant", {7'd0, bus.last_grant}, 8'h01);
        check("rst_busy", {7'd0, bus.busy}, {4'h0, BUSY_RST});
        rst = 1'b0;
`ifdef DRAM64X4_ARB_CLEAR_EN
        sweep_wait(64);
`endif
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("run_busy", {7'd0, bus.busy}, 8'h00);
    endtask
    initial begin
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.rd_addr_c = '0;
        reset_seq();
`ifdef DRAM64X4_ARB_CLEAR_EN
        bus.rd_addr_a = 6'd0;  #1; check("clr_a0",  {4'h0, bus.rd_data_a}, 8'h0A);
        bus.rd_addr_a = 6'd31; #1; check("clr_a31", {4'h0, bus.rd_data_a}, 8'h0A);
        bus.rd_addr_a = 6'd63; #1; check("clr_a63", {4'h0, bus.rd_data_a}, 8'h0A);
`else
        bus.rd_addr_a = 6'd7;  #1; check("init_a7", {4'h0, bus.rd_data_a}, 8'h0F);
`endif
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd5; bus.req0_data = 4'h3;
        bus.rd_addr_b = 6'd5;
        #1;
        check("single_r0", {7'd0, bus.req0_ready}, 8'h01);
        check("single_r1", {7'd0, bus.req1_ready}, 8'h00);
        check("single_pre", {4'h0, bus.rd_data_b}, {4'h0, P5});
        tick();
        bus.req0_valid = 1'b0;
        #1;
        check("single_post", {4'h0, bus.rd_data_b}, 8'h03);
        check("single_lg", {7'd0, bus.last_grant}, 8'h00);
        reset_seq();
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd10; bus.req0_data = 4'h1;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd10; bus.req1_data = 4'h2;
        bus.rd_addr_c = 6'd10;
        #1;
        check("cont1_ready", {6'd0, bus.req0_ready, bus.req1_ready}, 8'h02);
        check("cont1_pre", {4'h0, bus.rd_data_c}, {4'h0, P10});
        tick();
        check("cont2_ready", {6'd0, bus.req0_ready, bus.req1_ready}, 8'h01);
        check("cont2_mem", {4'h0, bus.rd_data_c}, 8'h01);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("cont_final", {4'h0, bus.rd_data_c}, 8'h02);
        check("cont_lg", {7'd0, bus.last_grant}, 8'h01);
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 8; k++) begin
            bus.req0_valid = 1'b1; bus.req0_addr = 6'(32 + i0); bus.req0_data = 4'(i0);
            bus.req1_valid = 1'b1; bus.req1_addr = 6'(48 + i1); bus.req1_data = 4'(15 - i1);
            #1;
            check("fair_ready", {6'd0, bus.req0_ready, bus.req1_ready}, (k % 2 == 0) ? 8'h02 : 8'h01);
            if (bus.req0_ready) i0++;
            if (bus.req1_ready) i1++;
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("fair_cnt0", 8'(i0), 8'd4);
        check("fair_cnt1", 8'(i1), 8'd4);
        check("fair_lg", {7'd0, bus.last_grant}, 8'h01);
        bus.rd_addr_a = 6'd33; bus.rd_addr_b = 6'd51; bus.rd_addr_c = 6'd35;
        #1;
        check("fair_m33", {4'h0, bus.rd_data_a}, 8'h01);
        check("fair_m51", {4'h0, bus.rd_data_b}, 8'h0C);
        check("fair_m35", {4'h0, bus.rd_data_c}, 8'h03);
`ifdef DRAM64X4_ARB_CLEAR_EN
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 6'd20; bus.req0_data = 4'h7;
        bus.req1_valid = 1'b1; bus.req1_addr = 6'd21; bus.req1_data = 4'h8;
        sweep_wait(30);
        rst = 1'b1;
        #1;
        check("mid_rst", {5'd0, bus.busy, bus.req0_ready, bus.req1_ready}, 8'h04);
        tick();
        rst = 1'b0;
        sweep_wait(64);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        check("mid_done", {7'd0, bus.busy}, 8'h00);
        bus.rd_addr_a = 6'd20; bus.rd_addr_b = 6'd63; bus.rd_addr_c = 6'd5;
        #1;
        check("mid_m20", {4'h0, bus.rd_data_a}, 8'h0A);
        check("mid_m63", {4'h0, bus.rd_data_b}, 8'h0A);
        check("mid_m5",  {4'h0, bus.rd_data_c}, 8'h0A);
`endif
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
